// File: rtl/input_shift_sequencer.sv
// Handshaked sequencer for the Viterbi input shift buffer and 2-bit symbol splitter.
// Optional stall counter output enabled by defining INPUT_SEQ_STALL_CNT_EN.
module input_shift_sequencer #(
   parameter int DATA_W = 16,
   parameter int SLOTS  = 8,
   parameter int PTR_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [SLOTS-1:0]  wr_en,
   output logic [DATA_W-1:0] wr_data,
   output logic              split_en,
   output logic [PTR_W-1:0]  split_phase,
   output logic              out_valid,
   output logic              frame_start,
`ifdef INPUT_SEQ_STALL_CNT_EN
   output logic              busy,
   output logic [7:0]        stall_cnt
`else
   output logic              busy
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam logic [PTR_W-1:0] LAST_SLOT  = PTR_W'(SLOTS - 1);
   localparam logic [PTR_W-1:0] LAST_DRAIN = PTR_W'(SLOTS - 2);
   localparam logic [SLOTS-1:0] SLOT0_MASK = SLOTS'(1);

   state_t           state;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] phase;
   logic [PTR_W-1:0] drain_cnt;
   logic             accept;

   // Flush wins over a same-cycle word so the drain never sees a half-written slot.
   assign in_ready = ((state == FILL) || (state == RUN)) && !flush;
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: every registered strobe is cleared here too, so nothing fires after reset release.
         state       <= IDLE;
         wr_ptr      <= '0;
         phase       <= '0;
         drain_cnt   <= '0;
         wr_en       <= '0;
         wr_data     <= '0;
         split_en    <= 1'b0;
         split_phase <= '0;
         out_valid   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; out_valid must see the previous split_en, not this cycle's.
         wr_en       <= '0;
         split_en    <= 1'b0;
         frame_start <= 1'b0;
         out_valid   <= split_en;
         unique case (state)
            IDLE: begin
               if (enable) begin
                  state  <= FILL;
                  wr_ptr <= '0;
                  phase  <= '0;
               end
            end
            FILL: begin
               if (flush) begin
                  state  <= IDLE;
                  wr_ptr <= '0;
                  phase  <= '0;
               end else if (accept) begin
                  wr_en   <= SLOT0_MASK << wr_ptr;
                  wr_data <= in_data;
                  wr_ptr  <= wr_ptr + 1'b1;
                  if (wr_ptr == LAST_SLOT) state <= RUN;
               end
            end
            RUN: begin
               if (flush) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end else if (accept) begin
                  wr_en       <= SLOT0_MASK << wr_ptr;
                  wr_data     <= in_data;
                  split_en    <= 1'b1;
                  split_phase <= phase;
                  frame_start <= (phase == '0);
                  wr_ptr      <= wr_ptr + 1'b1;
                  phase       <= phase + 1'b1;
               end
            end
            DRAIN: begin
               // Push the SLOTS-1 symbol pairs still held in the splitter.
               split_en    <= 1'b1;
               split_phase <= phase;
               frame_start <= (phase == '0);
               phase       <= phase + 1'b1;
               drain_cnt   <= drain_cnt + 1'b1;
               if (drain_cnt == LAST_DRAIN) begin
                  state  <= IDLE;
                  wr_ptr <= '0;
                  phase  <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef INPUT_SEQ_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if ((state == IDLE) && enable) begin
         stall_cnt <= '0;
      end else if ((state == RUN) && !in_valid && (stall_cnt != 8'hFF)) begin
         stall_cnt <= stall_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_input_shift_sequencer.sv
// Randomized bench for input_shift_sequencer against a word-count based reference model.
module tb_input_shift_sequencer;

   localparam int M_IDLE  = 0;
   localparam int M_FILL  = 1;
   localparam int M_RUN   = 2;
   localparam int M_DRAIN = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable, flush, in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic [7:0]  wr_en;
   logic [15:0] wr_data;
   logic        split_en;
   logic [2:0]  split_phase;
   logic        out_valid, frame_start, busy;
`ifdef INPUT_SEQ_STALL_CNT_EN
   logic [7:0]  stall_cnt;
`endif

   input_shift_sequencer dut (
      .clk(clk), .rst(rst), .enable(enable), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .wr_en(wr_en), .wr_data(wr_data), .split_en(split_en),
      .split_phase(split_phase), .out_valid(out_valid),
      .frame_start(frame_start),
`ifdef INPUT_SEQ_STALL_CNT_EN
      .busy(busy), .stall_cnt(stall_cnt)
`else
      .busy(busy)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: everything derives from the number of words accepted this session.
   int          mode;
   int          n_acc;
   int          drain_k;
   int          stall_m;
   logic [7:0]  e_wr;
   logic [15:0] e_wd;
   logic        e_sp, e_ov, e_fs;
   logic [2:0]  e_ph;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mode = M_IDLE; n_acc = 0; drain_k = 0; stall_m = 0;
      e_wr = '0; e_wd = '0; e_sp = 1'b0; e_ov = 1'b0; e_fs = 1'b0; e_ph = '0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_wr_en"}, 32'(wr_en), 0);
      check({tag, "_wr_data"}, 32'(wr_data), 0);
      check({tag, "_split_en"}, 32'(split_en), 0);
      check({tag, "_split_phase"}, 32'(split_phase), 0);
      check({tag, "_out_valid"}, 32'(out_valid), 0);
      check({tag, "_frame_start"}, 32'(frame_start), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_in_ready"}, 32'(in_ready), 0);
`ifdef INPUT_SEQ_STALL_CNT_EN
      check({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
`endif
   endtask

   // One clock: drive inputs, check in_ready, advance model across the edge, check outputs.
   task automatic cycle(input logic en, input logic fl, input logic v, input logic [15:0] d);
      logic rdy, acc;
      enable = en; flush = fl; in_valid = v; in_data = d;
      #1;
      rdy = ((mode == M_FILL) || (mode == M_RUN)) && !fl;
      acc = v && rdy;
      check("in_ready", 32'(in_ready), 32'(rdy));
      e_ov = e_sp;
      e_wr = '0; e_sp = 1'b0; e_fs = 1'b0;
      if ((mode == M_RUN) && !v && (stall_m < 255)) stall_m++;
      case (mode)
         M_IDLE: if (en) begin mode = M_FILL; n_acc = 0; stall_m = 0; end
         M_FILL: begin
            if (fl) mode = M_IDLE;
            else if (acc) begin
               e_wr = 8'(1 << (n_acc % 8)); e_wd = d;
               n_acc++;
               if (n_acc == 8) mode = M_RUN;
            end
         end
         M_RUN: begin
            if (fl) begin mode = M_DRAIN; drain_k = 0; end
            else if (acc) begin
               e_wr = 8'(1 << (n_acc % 8)); e_wd = d;
               e_sp = 1'b1; e_ph = 3'(n_acc % 8); e_fs = (n_acc % 8) == 0;
               n_acc++;
            end
         end
         default: begin
            e_sp = 1'b1; e_ph = 3'((n_acc + drain_k) % 8); e_fs = ((n_acc + drain_k) % 8) == 0;
            drain_k++;
            if (drain_k == 7) mode = M_IDLE;
         end
      endcase
      @(posedge clk);
      #1;
      check("wr_en", 32'(wr_en), 32'(e_wr));
      if (e_wr != 0) check("wr_data", 32'(wr_data), 32'(e_wd));
      check("split_en", 32'(split_en), 32'(e_sp));
      if (e_sp) check("split_phase", 32'(split_phase), 32'(e_ph));
      check("out_valid", 32'(out_valid), 32'(e_ov));
      check("frame_start", 32'(frame_start), 32'(e_fs));
      check("busy", 32'(busy), 32'(mode != M_IDLE));
`ifdef INPUT_SEQ_STALL_CNT_EN
      check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
`endif
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      // Prime: enable, then 8 back-to-back words 1..8.
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b0, 1'b1, 16'(i));
      check("primed_run", 32'(mode), M_RUN);

      // Steady run: 16 words, two full frames.
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b1, 16'($urandom));

      // Advance to phase 4, stall 3 cycles, resume.
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 16'($urandom));
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 16'($urandom));
`ifdef INPUT_SEQ_STALL_CNT_EN
      check("stall_cnt_3", 32'(stall_cnt), 3);
`endif
      cycle(1'b0, 1'b0, 1'b1, 16'($urandom));
      check("resume_slot4", 32'(wr_en), 32'h10);

      // Random valid pattern.
      for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), 16'($urandom));

      // Flush colliding with a valid word at phase 2.
      for (int i = 0; i < 16 && (n_acc % 8) != 2; i++) cycle(1'b0, 1'b0, 1'b1, 16'($urandom));
      cycle(1'b0, 1'b1, 1'b1, 16'($urandom));
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
      check("drain_idle", 32'(busy), 0);

      // New fill starts at slot 0; flush after 5 words.
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 16'($urandom));
      cycle(1'b0, 1'b1, 1'b1, 16'($urandom));
      for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, 16'($urandom));

      // Re-enable, full fill from slot 0, run to phase 5, then reset with in_valid high.
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      cycle(1'b0, 1'b0, 1'b1, 16'hA5A5);
      check("refill_slot0", 32'(wr_en), 32'h01);
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1, 16'($urandom));
      for (int i = 0; i < 16 && (n_acc % 8) != 6; i++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), 16'($urandom));
      check("phase5_strobe", 32'(split_phase), 5);
      in_valid = 1'b1;
      rst = 1'b1;
      #1;
      check_zero("mid_reset");
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 16'($urandom));

`ifdef INPUT_SEQ_STALL_CNT_EN
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 16'($urandom));
      for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 1'b0, 16'($urandom));
      check("stall_cnt_sat", 32'(stall_cnt), 255);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
